// File: rtl/cgra_x_heep_pkg.sv
// CGRA <-> X-HEEP integration constants, including the OBI master arbiter
// defaults (upstream master count, outstanding depth, grant index type).
package cgra_x_heep_pkg;

    localparam int unsigned CGRA_ARB_N_REQ     = 32'd4;
    localparam int unsigned CGRA_ARB_MAX_OUTST = 32'd2;

    typedef logic [$clog2(CGRA_ARB_N_REQ)-1:0] cgra_arb_idx_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the X-HEEP external crossbar ports.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cgra_arb_idx_fifo.sv
// Small synchronous FIFO holding the master index of every granted but not
// yet answered OBI transaction. Push and pop may happen in the same cycle;
// a push while full or a pop while empty is ignored.
module cgra_arb_idx_fifo
    import cgra_x_heep_pkg::*;
#(
    parameter int unsigned DEPTH = CGRA_ARB_MAX_OUTST,
    parameter int unsigned WIDTH = $bits(cgra_arb_idx_t)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Advance a pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] nxt;
        if (p == PTR_W'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = p + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full      = (occ_r == OCC_W'(DEPTH));
    assign empty     = (occ_r == '0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; reset flushes every entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: rtl/cgra_obi_master_arbiter.sv
// Round-robin arbiter sharing one X-HEEP external-crossbar OBI master port
// between N_REQ CGRA-side masters. The winner is locked while its address
// phase waits for gnt; granted indices are queued so each rvalid/rdata is
// routed back to the issuing master.
// Optional feature: define CGRA_OBI_ARB_GRANT_CNT_EN to build per-master
// saturating grant counters; otherwise grant_cnt_o is tied to zero.
module cgra_obi_master_arbiter
    import obi_pkg::*;
    import cgra_x_heep_pkg::*;
#(
    parameter int unsigned N_REQ     = CGRA_ARB_N_REQ,
    parameter int unsigned MAX_OUTST = CGRA_ARB_MAX_OUTST,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  obi_req_t  [N_REQ-1:0]       req_i,
    output obi_resp_t [N_REQ-1:0]       resp_o,
    output obi_req_t                    req_o,
    input  obi_resp_t                   resp_i,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    idx_t rr_q;
    logic lock_q;
    idx_t lock_idx_q;
    logic err_r;

    idx_t win_idx_s;
    logic win_vld_s;
    idx_t cand_s;
    logic req_vld_s;
    logic hs_s;
    logic pop_s;
    idx_t head_s;
    logic full_s;
    logic empty_s;

    // (base + off) mod N_REQ for base, off < N_REQ.
    function automatic idx_t rr_offset(input idx_t base, input int unsigned off);
        int unsigned sum_v;
        sum_v = 32'(base) + off;
        if (sum_v >= N_REQ) begin
            sum_v = sum_v - N_REQ;
        end
        return idx_t'(sum_v);
    endfunction

    // Winner selection: locked index while an address phase is pending,
    // otherwise first requester at or after rr_q (scanned farthest-first so
    // the nearest requester is the last assignment).
    always_comb begin
        win_idx_s = rr_q;
        win_vld_s = 1'b0;
        cand_s    = rr_q;
        if (lock_q) begin
            win_idx_s = lock_idx_q;
            win_vld_s = req_i[lock_idx_q].req;
        end else begin
            for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
                cand_s = rr_offset(rr_q, i);
                if (req_i[cand_s].req) begin
                    win_idx_s = cand_s;
                    win_vld_s = 1'b1;
                end else begin
                    win_idx_s = win_idx_s;
                end
            end
        end
    end

    // A full index queue blocks the request; no same-cycle bypass on pop.
    assign req_vld_s = win_vld_s & ~full_s;
    assign hs_s      = req_vld_s & resp_i.gnt;
    assign pop_s     = resp_i.rvalid & ~empty_s;
    assign busy_o    = ~empty_s | req_vld_s;
    assign err_o     = err_r;

    // Downstream request mirrors the winner; all zeros when nobody requests.
    always_comb begin
        req_o = '0;
        if (win_vld_s) begin
            req_o     = req_i[win_idx_s];
            req_o.req = req_vld_s;
        end else begin
            req_o = '0;
        end
    end

    // Upstream responses: gnt to the current winner, rvalid/rdata to the queue head.
    always_comb begin
        resp_o = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            resp_o[k].gnt    = hs_s & (idx_t'(k) == win_idx_s);
            resp_o[k].rvalid = pop_s & (idx_t'(k) == head_s);
            resp_o[k].rdata  = resp_o[k].rvalid ? resp_i.rdata : 32'h0000_0000;
        end
    end

    // Round-robin pointer and address-phase lock.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (hs_s) begin
            rr_q   <= rr_offset(win_idx_s, 1);
            lock_q <= 1'b0;
        end else if (req_vld_s) begin
            lock_q     <= 1'b1;
            lock_idx_q <= win_idx_s;
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (resp_i.rvalid && empty_s) begin
            err_r <= 1'b1;
        end
    end

    cgra_arb_idx_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_idx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (hs_s),
        .wdata  (win_idx_s),
        .pop    (pop_s),
        .rdata  (head_s),
        .full   (full_s),
        .empty  (empty_s)
    );

`ifdef CGRA_OBI_ARB_GRANT_CNT_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt_r;

    // Per-master handshake counters, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (hs_s && (win_idx_s == idx_t'(k)) && (cnt_r[k] != '1)) begin
                    cnt_r[k] <= cnt_r[k] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt_o = cnt_r;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/cgra_obi_master_arbiter.md
# cgra_obi_master_arbiter

Round-robin arbiter that shares one X-HEEP external-crossbar OBI master port between `N_REQ` CGRA-side OBI masters, such as per-column load/store units. It sits between `cgra_top_wrapper` and the `ext_xbar_master_req/resp` pair of `x_heep_system`, so the CGRA can have more memory masters than `EXT_XBAR_NMASTER` provides. It tracks outstanding transactions in an index FIFO and routes each `rvalid`/`rdata` back to the master that issued the request.

## Interface
Parameters:
- `N_REQ`, 4: number of upstream CGRA masters (≥2).
- `MAX_OUTST`, 2: maximum outstanding granted-but-unanswered transactions; also the index FIFO depth (≥1).
- `CNT_W`, 32: width of each grant counter.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset. One clock; reset is synchronous and active-low.
- `req_i`  in  `obi_req_t [N_REQ]`  upstream requests (`req`, `we`, `be`, `addr`, `wdata`).
- `resp_o`  out  `obi_resp_t [N_REQ]`  upstream responses (`gnt`, `rvalid`, `rdata`).
- `req_o`  out  `obi_req_t`  downstream request to the xbar master port.
- `resp_i`  in  `obi_resp_t`  downstream response.
- `busy_o`  out  1  high when the FIFO is non-empty or `req_o.req` is high.
- `err_o`  out  1  sticky; set when `rvalid` arrives while the FIFO is empty.
- `grant_cnt_o`  out  `[N_REQ][CNT_W]`  grants per master (see Configuration).

## Operation
- Round-robin pointer `rr_q` (log2 `N_REQ` bits). The winner is the first requester with `req_i[k].req`, searching from `rr_q` upward with modulo wrap.
- Lock: once `req_o.req` has been driven and not granted, `lock_q`=1 and `lock_idx_q` holds the winner. The winner stays fixed until `resp_i.gnt`, because OBI requires a stable address phase. Other requesters are ignored while locked.
- `req_o` carries the winner's fields. `req_o.req` = winner valid & !fifo_full. When no requester is active, `req_o` is all zeros.
- `resp_o[k].gnt` = `resp_i.gnt` & (k == winner) & `req_o.req`. All other `gnt` outputs are 0.
- Handshake (`req_o.req` & `resp_i.gnt`):
  - push the winner index into the FIFO;
  - `rr_q` ← winner+1 mod `N_REQ`;
  - `lock_q` ← 0.
- `resp_i.rvalid`: pop the FIFO head h. Drive `resp_o[h].rvalid`=1 and `resp_o[h].rdata`=`resp_i.rdata`. Non-selected `rdata` outputs are 0.
- Full FIFO: `req_o.req` is forced low even if a pop occurs in the same cycle. There is no same-cycle bypass.
- Empty FIFO and `rvalid`: the response is dropped and `err_o` is set. It clears only on reset.
- Simultaneous push and pop with a non-empty FIFO: both happen, and the occupancy is unchanged.
- Reset mid-transaction: the FIFO is flushed, `rr_q`=0 and `lock_q`=0. Stray `rvalid` after reset sets `err_o`, which is intended behaviour.
- Reset values: all `resp_o` 0, `req_o` 0, `busy_o` 0, `err_o` 0, `grant_cnt_o` 0.

## Timing
- Request path is combinational, zero cycles from `req_i` to `req_o`; the winner is evaluated from registered `rr_q`/`lock_q`.
- Grant path is combinational from `resp_i.gnt` to `resp_o[k].gnt`.
- Response path is combinational from `resp_i.rvalid` to `resp_o[h].rvalid`. Routing uses the registered FIFO head.
- `rr_q`, `lock_q`, the FIFO, counters and `err_o` update on the rising edge of `clk_i`.
- Back-to-back grants to different masters are possible every cycle while the FIFO is not full.

## Configuration
- Macro `CGRA_OBI_ARB_GRANT_CNT_EN`.
- Defined: one `CNT_W` counter per master increments on each handshake for that master. It saturates at all-ones and resets to 0.
- Undefined: no counter flops are built and `grant_cnt_o` is tied to 0.

## Structure
- Add to `cgra_x_heep_pkg`:
  - `CGRA_ARB_N_REQ` and `CGRA_ARB_MAX_OUTST` constants;
  - typedef `cgra_arb_idx_t` (log2 `N_REQ` bits).
- `obi_req_t`/`obi_resp_t` come from `obi_pkg`.
- One sub-module, `cgra_arb_idx_fifo`: a synchronous FIFO of `cgra_arb_idx_t` of depth `MAX_OUTST`. Outputs `full`/`empty`; push and pop are allowed in the same cycle.

## Test plan
1. Reset, then all four masters request reads simultaneously with `gnt` always 1 and `rvalid` one cycle later → grants in order 0,1,2,3; each `rdata` returns to the issuer; `grant_cnt_o`={1,1,1,1}.
2. Master 2 requests with `gnt` held 0 for 5 cycles while master 0 also raises `req` → `req_o.addr` stays master 2's for all 5 cycles; master 0 is granted next.
3. `MAX_OUTST`=2, `gnt`=1, `rvalid` withheld → two grants, then `req_o.req`=0 and `busy_o`=1. After one `rvalid`, the next grant occurs on the following cycle.
4. Pipelined: master 1 granted in cycle t, master 3 in t+1, `rvalid` in t+1 and t+2 → master 1's response in t+1 and master 3's in t+2, with push and pop in the same cycle in t+1.
5. `rvalid` pulse with no outstanding transactions → `err_o`=1 and stays 1; no `resp_o[k].rvalid` asserted.
6. `rst_ni`=0 for one cycle with 2 outstanding transactions → FIFO empty, `busy_o`=0, all outputs 0 at the next edge; the next arbitration starts at master 0.
